// File: rtl/lenet_layer_scheduler.sv
// Layer sequencer for the shared LeNet compute engine: walks CONV1..FC2, issuing one
// start pulse per layer with registered configuration, guarded by a per-layer watchdog.
module lenet_layer_scheduler #(
  parameter logic [15:0] WB_CONV1 = 16'd0,
  parameter logic [15:0] WB_CONV2 = 16'd60,
  parameter logic [15:0] WB_CONV3 = 16'd660,
  parameter logic [15:0] WB_FC1   = 16'd12660,
  parameter logic [15:0] WB_FC2   = 16'd15180,
  parameter logic [23:0] TIMEOUT  = 24'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        compute_start,
  input  logic [31:0] scale_CONV1,
  input  logic [31:0] scale_CONV2,
  input  logic [31:0] scale_CONV3,
  input  logic [31:0] scale_FC1,
  input  logic [31:0] scale_FC2,
  input  logic        layer_done,
  output logic        layer_start,
  output logic [2:0]  layer_id,
  output logic [9:0]  act_in_base,
  output logic [9:0]  act_out_base,
  output logic [15:0] weight_base,
  output logic [31:0] scale,
  output logic        busy,
  output logic        compute_finish,
  output logic        error,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  layer_id_q, layer_id_d;
  logic [9:0]  act_in_base_q, act_in_base_d;
  logic [9:0]  act_out_base_q, act_out_base_d;
  logic [15:0] weight_base_q, weight_base_d;
  logic [31:0] scale_q, scale_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [23:0] wd_q, wd_d;
  logic        load;
  logic [2:0]  load_id;

  // Activation buffers are chained: each layer reads where the previous one wrote.
  function automatic logic [9:0] act_out_of(input logic [2:0] id);
    case (id)
      3'd0:    act_out_of = 10'd256;
      3'd1:    act_out_of = 10'd592;
      3'd2:    act_out_of = 10'd692;
      3'd3:    act_out_of = 10'd722;
      default: act_out_of = 10'd743;
    endcase
  endfunction

  function automatic logic [9:0] act_in_of(input logic [2:0] id);
    act_in_of = (id == 3'd0) ? 10'd0 : act_out_of(id - 3'd1);
  endfunction

  function automatic logic [15:0] weight_of(input logic [2:0] id);
    case (id)
      3'd0:    weight_of = WB_CONV1;
      3'd1:    weight_of = WB_CONV2;
      3'd2:    weight_of = WB_CONV3;
      3'd3:    weight_of = WB_FC1;
      default: weight_of = WB_FC2;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign layer_start    = (state_q == S_ISSUE);
  assign busy           = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);
  assign compute_finish = (state_q == S_DONE) || (state_q == S_ERR);
  assign error          = (state_q == S_ERR);

  always_comb begin
    state_d        = state_q;
    layer_id_d     = layer_id_q;
    act_in_base_d  = act_in_base_q;
    act_out_base_d = act_out_base_q;
    weight_base_d  = weight_base_q;
    scale_d        = scale_q;
    wd_d           = wd_q;
    cycle_count_d  = busy ? sat_inc(cycle_count_q) : cycle_count_q;
    load           = 1'b0;
    load_id        = layer_id_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (compute_start) begin
          load          = 1'b1;
          load_id       = 3'd0;
          cycle_count_d = 32'd0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = 24'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the watchdog's final cycle still counts as success.
        if (layer_done)                     state_d = S_NEXT;
        else if (wd_q == TIMEOUT - 24'd1)   state_d = S_ERR;
        else                                wd_d    = wd_q + 24'd1;
      end
      S_NEXT: begin
        if (layer_id_q == 3'd4) begin
          state_d = S_DONE;
        end else begin
          load    = 1'b1;
          load_id = layer_id_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      layer_id_d     = load_id;
      act_in_base_d  = act_in_of(load_id);
      act_out_base_d = act_out_of(load_id);
      weight_base_d  = weight_of(load_id);
      case (load_id)
        3'd0:    scale_d = scale_CONV1;
        3'd1:    scale_d = scale_CONV2;
        3'd2:    scale_d = scale_CONV3;
        3'd3:    scale_d = scale_FC1;
        default: scale_d = scale_FC2;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      layer_id_q     <= 3'd0;
      act_in_base_q  <= 10'd0;
      act_out_base_q <= 10'd0;
      weight_base_q  <= 16'd0;
      scale_q        <= 32'd0;
      cycle_count_q  <= 32'd0;
      wd_q           <= 24'd0;
    end else begin
      state_q        <= state_d;
      layer_id_q     <= layer_id_d;
      act_in_base_q  <= act_in_base_d;
      act_out_base_q <= act_out_base_d;
      weight_base_q  <= weight_base_d;
      scale_q        <= scale_d;
      cycle_count_q  <= cycle_count_d;
      wd_q           <= wd_d;
    end
  end

  assign layer_id     = layer_id_q;
  assign act_in_base  = act_in_base_q;
  assign act_out_base = act_out_base_q;
  assign weight_base  = weight_base_q;
  assign scale        = scale_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: doc/lenet_layer_scheduler.md
# lenet_layer_scheduler

Sequences the five LeNet layers (CONV1, CONV2, CONV3, FC1, FC2) on the shared compute engine. A single `compute_start` pulse launches the run. For each layer the block issues one start pulse together with a stable per-layer configuration: activation input/output base, weight base and quantization scale. It then waits for the engine's done pulse, and after FC2 it raises `compute_finish`. It sits between the top-level `lenet` control ports and the engine datapath, and also provides a per-layer watchdog and a run cycle counter.

## Interface
- `WB_CONV1`, 16'd0, weight SRAM word base for CONV1
- `WB_CONV2`, 16'd60, weight base for CONV2
- `WB_CONV3`, 16'd660, weight base for CONV3
- `WB_FC1`, 16'd12660, weight base for FC1
- `WB_FC2`, 16'd15180, weight base for FC2
- `TIMEOUT`, 24'd20000, maximum cycles allowed in WAIT per layer
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `compute_start` in 1: run request pulse.
- `scale_CONV1`, `scale_CONV2`, `scale_CONV3`, `scale_FC1`, `scale_FC2` in 32 each: per-layer scales.
- `layer_done` in 1: engine finished the current layer (one-cycle pulse).
- `layer_start` out 1: one-cycle pulse that launches the engine on the current layer.
- `layer_id` out 3: 0=CONV1, 1=CONV2, 2=CONV3, 3=FC1, 4=FC2.
- `act_in_base` out 10: activation SRAM word base of the layer input.
- `act_out_base` out 10: activation SRAM word base of the layer output.
- `weight_base` out 16: weight SRAM word base.
- `scale` out 32: scale for the current layer.
- `busy` out 1: a run is in progress.
- `compute_finish` out 1: run ended. Level signal, held until the next accepted start.
- `error` out 1: the run ended by watchdog timeout. Level signal, held until the next accepted start.
- `cycle_count` out 32: cycles of the last or current run.

## Operation
- Activation map (fixed, words): image 0, CONV1 256, CONV2 592, CONV3 692, FC1 722, FC2 743.
  - Layer n input base = output base of layer n-1 (image for CONV1).
  - (in, out) pairs: CONV1 (0,256), CONV2 (256,592), CONV3 (592,692), FC1 (692,722), FC2 (722,743).
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE, ERR.
- IDLE/DONE/ERR + `compute_start`=1:
  - `layer_id`←0 and config loaded for CONV1;
  - `compute_finish`, `error` and `cycle_count` cleared;
  - go to ISSUE.
- ISSUE: `layer_start`=1 for exactly this cycle; watchdog cleared; go to WAIT.
- WAIT:
  - `layer_done`=1 → NEXT.
  - Otherwise, if watchdog = TIMEOUT-1 → ERR.
  - Otherwise watchdog+1.
- NEXT:
  - if `layer_id`==4 → DONE;
  - else `layer_id`+1, config reloaded for the new layer, → ISSUE.
- DONE: `compute_finish`=1. ERR: `compute_finish`=1 and `error`=1. Config outputs hold their last values in both.
- `compute_start` in ISSUE/WAIT/NEXT is ignored; no restart mid-run.
- `layer_done` outside WAIT is ignored and does not advance the layer.
- `layer_done` in the same cycle the watchdog reaches TIMEOUT-1: done wins, go to NEXT.
- `scale_*` inputs are sampled into `scale` at load time (start or NEXT). Later changes to the inputs do not affect the current layer.
- `cycle_count` increments every cycle `busy`=1 and saturates at 32'hFFFFFFFF.
- `busy`=1 in ISSUE, WAIT and NEXT.

## Timing
- Reset values:
  - state IDLE;
  - `layer_start`, `busy`, `compute_finish`, `error` = 0;
  - `layer_id`, `act_in_base`, `act_out_base`, `weight_base`, `scale`, `cycle_count` = 0.
- `compute_start` is sampled at rising edge k; `layer_start` and `busy` are high in cycle k+1.
- Config outputs are registered. They are valid in the `layer_start` cycle and stable until the next NEXT.
- `layer_done` is sampled at edge m:
  - NEXT in cycle m+1;
  - the next `layer_start` in cycle m+2;
  - for FC2, `compute_finish` rises in cycle m+2.
- Minimum run with zero-latency engine (done in the cycle after each `layer_start`): 5×3 = 15 busy cycles. `cycle_count` = 15.
- Asserting `rst` mid-run forces IDLE immediately (asynchronously): all outputs go to their reset values and `layer_start` is not re-emitted.

## Test plan
- Nominal run:
  - Stimulus: start pulse; engine answers each `layer_start` with `layer_done` 10 cycles later.
  - Response: exactly five `layer_start` pulses with `layer_id` 0..4.
  - Bases per pulse match the map: CONV1 (0,256,0), FC2 (722,743,15180).
  - `scale` is 96/85/265/438/217 with those scale inputs.
  - `compute_finish`=1, `error`=0, `cycle_count`=60.
- Watchdog: TIMEOUT=50 and CONV2 never answers → `error`=1 and `compute_finish`=1 after 50 WAIT cycles; `layer_id`=1.
- Done/timeout collision: `layer_done` on the watchdog's final cycle → no error; proceeds to layer 2.
- Spurious inputs:
  - `compute_start` during WAIT → ignored; no extra `layer_start`.
  - `layer_done` during IDLE or ISSUE → `layer_id` unchanged.
- Reset mid-run: assert `rst` during FC1 WAIT → all outputs return to reset values. A new start then runs cleanly from CONV1.
- Back-to-back runs:
  - `compute_start` while in DONE → `compute_finish` drops the next cycle and the second run completes identically.
  - Scale inputs changed between runs are picked up by the second run.
